uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter, the TX half of the APB_UART serial link. It accepts one parallel character per valid/ready handshake and serialises it LSB-first on `tx` as start, data, optional parity and stop bits. Bit timing comes from the shared one-cycle `baud_tick` strobe, and frame format comes from the same 5-bit `cfg_reg` encoding the receiver uses. Frames it produces are bit-exact what the receiver checks.

Parameters:
- IDLE_LEVEL, 1'b1, line level driven in idle and stop states.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clk pulse per bit period.
- cfg_reg  input  5  frame format: [1:0] data_bits (00=5, 01=6, 10=7, 11=8); [2] stop_bits (0=1, 1=2); [3] parity_en; [4] parity_type (0=even, 1=odd).
- tx_data  input  8  character to send; bits above the configured length are ignored.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  block can accept a character this cycle.
- tx  output  1  serial line.
- tx_busy  output  1  a frame is pending or in progress.
- tx_done  output  1  one-clk pulse when the final stop bit ends.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, tx=IDLE_LEVEL, tx_done=0, tx_busy=0, tx_ready=1, shift/counters=0.
- Reset mid-frame aborts the frame; tx returns to 1 at that edge.
- Handshake:
  - tx_ready = (state==IDLE).
  - Transfer occurs when tx_valid && tx_ready. tx_data and cfg_reg are latched into shadow registers at that cycle.
  - cfg_reg and tx_data changes after acceptance are ignored until the next transfer.
- tx_busy = !tx_ready. tx is registered.
- States and transitions. Every bit transition happens on a clk edge where baud_tick=1; without baud_tick the state and tx hold.
  - IDLE: tx=1; baud_tick ignored. On transfer -> LOAD. A baud_tick coincident with acceptance is not used.
  - LOAD: on tick, tx<=0 (start bit), -> START.
  - START: on tick, tx<=data[0], bit_cnt<=0, -> DATA.
  - DATA: on tick:
    - if bit_cnt < len-1: bit_cnt++, tx<=data[bit_cnt+1].
    - else if parity_en: tx<=parity, -> PARITY.
    - else: tx<=1, stop_cnt<=0, -> STOP.
  - PARITY: on tick, tx<=1, stop_cnt<=0, -> STOP.
  - STOP: on tick:
    - if stop_cnt < stop_len-1: stop_cnt++ (tx stays 1).
    - else: tx_done<=1 for one cycle, -> IDLE.
- Parity = XOR(data[len-1:0]) ^ parity_type. Even parity gives an even total of ones; odd gives odd.
- Timing: tx_done rises on the (2+N+P+S)-th tick after acceptance, where N=data bits, P=parity_en, S=stop bits. Example: 8N1 = 11 ticks.
- Every bit, including the start bit, lasts exactly one full tick-to-tick period.
- Back-to-back frames: tx_ready is 1 in the cycle after tx_done. The next start bit begins at the following tick, so the line is high for at least one full bit period between frames.
- tx_valid held while busy is not accepted. No data is lost or duplicated; the sender keeps it asserted.

Optional Feature:
UART_TX_BREAK_EN: adds input port `tx_break` (1 bit).
- With the macro:
  - tx_break=1 sampled in IDLE (takes priority over tx_valid) -> state BREAK.
  - In BREAK: tx=0, tx_ready=0, tx_busy=1.
  - BREAK exits to IDLE on the first baud_tick with tx_break=0, with tx<=1 at that edge.
  - tx_break asserted mid-frame has no effect until the frame completes.
  - Reset clears BREAK.
- Without the macro: no `tx_break` port, no BREAK state; behaviour is exactly as above.

Test Plan:
- 8N1 (cfg=5'b00011), tx_data=0xA5 -> per tick: 0,1,0,1,0,0,1,0,1,1. tx_done on the 11th tick; tx_ready back the next cycle.
- 7E1 (cfg=5'b01010), tx_data=0x53 -> data 1,1,0,0,1,0,1; parity 0; one stop bit; tx_done on the 11th tick. Repeat with odd (cfg=5'b11010): parity 1.
- 5-bit, 2 stop, even parity (cfg=5'b01100), tx_data=0xFF -> 0, five 1s, parity 1, two stop 1s. Upper 3 bits not sent; tx_done on the 10th tick.
- Back-to-back: tx_valid held with 0x55 then 0x0F (8N1). The second frame is accepted the cycle after the first tx_done. Line idle ≥1 bit; no tick-coincident acceptance used as a start.
- cfg_reg changed from 8N1 to 5N1 mid-frame -> current frame completes as 8N1. rst pulsed in DATA -> tx=1, tx_ready=1 next cycle, no tx_done.
- (UART_TX_BREAK_EN) tx_break=1 for 3 ticks in IDLE -> tx=0, tx_ready=0. tx returns to 1 at the first tick after release, then a 0x41 frame transmits normally.

Source files
------------

// File: rtl/uart_tx_if.sv
// Character handshake between a UART transmitter and its sender.
// The sender drives data/valid on the master modport and the transmitter answers with ready.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: serialises one latched character per baud_tick as start/data/parity/stop.
// Optional line-break support is enabled with the UART_TX_BREAK_EN macro (adds the tx_break port).
module uart_tx #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [4:0] cfg_reg,
`ifdef UART_TX_BREAK_EN
    input  logic       tx_break,
`endif
    uart_tx_if.slave   tx_if,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
`ifdef UART_TX_BREAK_EN
        , StBreak
`endif
    } state_e;

    state_e     r_state, w_state;
    logic       r_tx, w_tx;
    logic       r_done, w_done;
    logic [7:0] r_data, w_data;
    logic [4:0] r_cfg, w_cfg;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic       r_stop_cnt, w_stop_cnt;

    logic       w_ready;
    logic [2:0] w_len_m1;
    logic [7:0] w_mask;
    logic       w_parity;

    // Frame format comes from the shadow copy, never from the live cfg_reg.
    assign w_len_m1 = 3'd4 + {1'b0, r_cfg[1:0]};
    assign w_mask   = 8'hFF >> (2'd3 - r_cfg[1:0]);
    assign w_parity = (^(r_data & w_mask)) ^ r_cfg[4];

    assign w_ready        = (r_state == StIdle);
    assign tx_if.tx_ready = w_ready;
    assign tx_busy        = ~w_ready;
    assign tx             = r_tx;
    assign tx_done        = r_done;

    always_comb begin
        w_state    = r_state;
        w_tx       = r_tx;
        w_done     = 1'b0;
        w_data     = r_data;
        w_cfg      = r_cfg;
        w_bit_cnt  = r_bit_cnt;
        w_stop_cnt = r_stop_cnt;
        case (r_state)
            StIdle: begin
                w_tx = IDLE_LEVEL;
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    w_state = StBreak;
                    w_tx    = ~IDLE_LEVEL;
                end else
`endif
                if (tx_if.tx_valid) begin
                    w_state = StLoad;
                    w_data  = tx_if.tx_data;
                    w_cfg   = cfg_reg;
                end
            end
            StLoad: begin
                if (baud_tick) begin
                    w_tx    = ~IDLE_LEVEL;
                    w_state = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    w_tx      = r_data[0];
                    w_bit_cnt = 3'd0;
                    w_state   = StData;
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (r_bit_cnt < w_len_m1) begin
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        w_tx      = r_data[w_bit_cnt];
                    end else if (r_cfg[3]) begin
                        w_tx    = w_parity;
                        w_state = StParity;
                    end else begin
                        w_tx       = IDLE_LEVEL;
                        w_stop_cnt = 1'b0;
                        w_state    = StStop;
                    end
                end
            end
            StParity: begin
                if (baud_tick) begin
                    w_tx       = IDLE_LEVEL;
                    w_stop_cnt = 1'b0;
                    w_state    = StStop;
                end
            end
            StStop: begin
                if (baud_tick) begin
                    if (!r_stop_cnt && r_cfg[2]) begin
                        w_stop_cnt = 1'b1;
                    end else begin
                        w_done  = 1'b1;
                        w_state = StIdle;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                w_tx = ~IDLE_LEVEL;
                if (baud_tick && !tx_break) begin
                    w_tx    = IDLE_LEVEL;
                    w_state = StIdle;
                end
            end
`endif
            default: begin
                w_tx    = IDLE_LEVEL;
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_tx       <= IDLE_LEVEL;
            r_done     <= 1'b0;
            r_data     <= 8'h00;
            r_cfg      <= 5'h00;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_tx       <= w_tx;
            r_done     <= w_done;
            r_data     <= w_data;
            r_cfg      <= w_cfg;
            r_bit_cnt  <= w_bit_cnt;
            r_stop_cnt <= w_stop_cnt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames from the test plan plus randomized frames,
// compared per baud tick against a bit-list model of the frame.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [4:0] cfg_reg;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
`ifdef UART_TX_BREAK_EN
    logic       tx_break;
`endif

    uart_tx_if tx_if ();

    uart_tx #(
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick),
        .cfg_reg  (cfg_reg),
`ifdef UART_TX_BREAK_EN
        .tx_break (tx_break),
`endif
        .tx_if    (tx_if),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level after each tick: start, data LSB first, parity, stop bits, then idle.
    function automatic void build_exp(input logic [4:0] cfg, input logic [7:0] d);
        int n_bits;
        int ones;
        n_bits = 5 + int'(cfg[1:0]);
        ones   = 0;
        exp_q  = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < n_bits; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (cfg[3]) exp_q.push_back(logic'(ones % 2) ^ cfg[4]);
        for (int s = 0; s < (cfg[2] ? 2 : 1); s++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
    endfunction

    // Random idle cycles (line must hold), then one tick cycle checked after its edge.
    task automatic tick_and_check(input string tag, input logic hold_tx, input logic exp_tx,
                                  input logic exp_done);
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            baud_tick = 1'b0;
            @(posedge clk);
            #1;
            check({tag, "_hold"}, tx, hold_tx);
            check({tag, "_hold_done"}, tx_done, 1'b0);
        end
        @(negedge clk);
        baud_tick = 1'b1;
        @(posedge clk);
        #1;
        check(tag, tx, exp_tx);
        check({tag, "_done"}, tx_done, exp_done);
    endtask

    task automatic start_frame(input logic [4:0] cfg, input logic [7:0] d, input logic tick_acc,
                               input logic hold);
        @(negedge clk);
        check("ready_pre", tx_if.tx_ready, 1'b1);
        cfg_reg        = cfg;
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        baud_tick      = tick_acc;
        @(posedge clk);
        #1;
        check("accept_ready", tx_if.tx_ready, 1'b0);
        check("accept_busy", tx_busy, 1'b1);
        check("accept_tx", tx, 1'b1);
        if (!hold) begin
            tx_if.tx_valid = 1'b0;
            cfg_reg        = 5'($urandom);
            tx_if.tx_data  = 8'($urandom);
        end
    endtask

    task automatic run_frame(input logic [4:0] cfg, input logic [7:0] d);
        logic prev;
        prev = 1'b1;
        build_exp(cfg, d);
        for (int i = 0; i < exp_q.size(); i++) begin
            tick_and_check($sformatf("bit%0d", i), prev, exp_q[i], logic'(i == exp_q.size() - 1));
            prev = exp_q[i];
        end
        check("ready_after_done", tx_if.tx_ready, 1'b1);
        check("busy_after_done", tx_busy, 1'b0);
        @(negedge clk);
        baud_tick = 1'b0;
        @(posedge clk);
        #1;
        check("done_pulse", tx_done, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       prev;
        logic [4:0] rc;
        logic [7:0] rd;
        rst            = 1'b1;
        baud_tick      = 1'b0;
        cfg_reg        = 5'b00011;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
`ifdef UART_TX_BREAK_EN
        tx_break       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", tx_if.tx_ready, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed frames from the test plan.
        start_frame(5'b00011, 8'hA5, 1'b0, 1'b0);
        run_frame(5'b00011, 8'hA5);
        start_frame(5'b01010, 8'h53, 1'b1, 1'b0);
        run_frame(5'b01010, 8'h53);
        start_frame(5'b11010, 8'h53, 1'b0, 1'b0);
        run_frame(5'b11010, 8'h53);
        start_frame(5'b01100, 8'hFF, 1'b0, 1'b0);
        run_frame(5'b01100, 8'hFF);

        // Back-to-back with tx_valid held: second char taken the cycle after tx_done.
        start_frame(5'b00011, 8'h55, 1'b0, 1'b1);
        tx_if.tx_data = 8'h0F;
        run_frame(5'b00011, 8'h55);
        check("b2b_accept", tx_if.tx_ready, 1'b0);
        tx_if.tx_valid = 1'b0;
        run_frame(5'b00011, 8'h0F);

        // Configuration switched to 5N1 mid-frame; frame must finish as 8N1.
        start_frame(5'b00011, 8'h3C, 1'b0, 1'b0);
        cfg_reg = 5'b00000;
        run_frame(5'b00011, 8'h3C);

        // Reset while in the data bits.
        start_frame(5'b00011, 8'hC3, 1'b0, 1'b0);
        build_exp(5'b00011, 8'hC3);
        prev = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_and_check($sformatf("abort_bit%0d", i), prev, exp_q[i], 1'b0);
            prev = exp_q[i];
        end
        @(negedge clk);
        baud_tick = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_ready", tx_if.tx_ready, 1'b1);
        check("abort_done", tx_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done_after", tx_done, 1'b0);
        check("abort_tx_after", tx, 1'b1);

`ifdef UART_TX_BREAK_EN
        @(negedge clk);
        baud_tick = 1'b0;
        tx_break  = 1'b1;
        @(posedge clk);
        #1;
        check("brk_tx", tx, 1'b0);
        check("brk_ready", tx_if.tx_ready, 1'b0);
        check("brk_busy", tx_busy, 1'b1);
        for (int i = 0; i < 3; i++) tick_and_check("brk_tick", 1'b0, 1'b0, 1'b0);
        check("brk_ready_held", tx_if.tx_ready, 1'b0);
        @(negedge clk);
        baud_tick = 1'b0;
        tx_break  = 1'b0;
        @(posedge clk);
        #1;
        check("brk_release_no_tick", tx, 1'b0);
        tick_and_check("brk_exit", 1'b0, 1'b1, 1'b0);
        check("brk_exit_ready", tx_if.tx_ready, 1'b1);
        start_frame(5'b00011, 8'h41, 1'b0, 1'b0);
        run_frame(5'b00011, 8'h41);
`endif

        // Randomized frames with random formats and tick placement.
        for (int k = 0; k < 40; k++) begin
            rc = 5'($urandom);
            rd = 8'($urandom);
            start_frame(rc, rd, 1'($urandom_range(0, 1)), 1'b0);
            run_frame(rc, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
